// File: rtl/gate_seq_ctrl.sv
// Gate self-test sequencer: steps {gate_a,gate_b} through 00,01,10,11, samples AND/OR results, reports pass/fail_vec.
// Optional GATE_SEQ_ERRCNT_EN adds a 4-bit err_cnt output counting individual mismatching signals.
module gate_seq_ctrl #(
  parameter int HOLD_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       gate_a,
  output logic       gate_b,
  input  logic       and_in,
  input  logic       or_in,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] fail_vec
`ifdef GATE_SEQ_ERRCNT_EN
  ,
  output logic [3:0] err_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [3:0] HOLD_RELOAD = 4'(HOLD_CYCLES - 1);

  state_t     state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic [3:0] cnt_q, cnt_d;
  logic       gate_a_q, gate_a_d;
  logic       gate_b_q, gate_b_d;
  logic       pass_q, pass_d;
  logic [3:0] fail_vec_q, fail_vec_d;
  logic       and_bad, or_bad;
`ifdef GATE_SEQ_ERRCNT_EN
  logic [3:0] err_cnt_q, err_cnt_d;
`endif

  // Compare against the operands actually on the gate inputs, not the next ones.
  assign and_bad = (and_in != (gate_a_q & gate_b_q));
  assign or_bad  = (or_in  != (gate_a_q | gate_b_q));

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    pass_d     = pass_q;
    fail_vec_d = fail_vec_q;
`ifdef GATE_SEQ_ERRCNT_EN
    err_cnt_d  = err_cnt_q;
`endif

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = DRIVE;
          idx_d      = 2'd0;
          cnt_d      = HOLD_RELOAD;
          fail_vec_d = 4'd0;
          pass_d     = 1'b0;
`ifdef GATE_SEQ_ERRCNT_EN
          err_cnt_d  = 4'd0;
`endif
        end
      end
      DRIVE: begin
        if (cnt_q == 4'd0) begin
          state_d = SAMPLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      SAMPLE: begin
        fail_vec_d[idx_q] = fail_vec_q[idx_q] | and_bad | or_bad;
`ifdef GATE_SEQ_ERRCNT_EN
        err_cnt_d = err_cnt_q + {3'd0, and_bad} + {3'd0, or_bad};
`endif
        if (idx_q == 2'd3) begin
          // pass is settled on entry to DONE so it is valid alongside the done pulse.
          state_d = DONE;
          pass_d  = (fail_vec_d == 4'd0);
        end else begin
          state_d = DRIVE;
          idx_d   = idx_q + 2'd1;
          cnt_d   = HOLD_RELOAD;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Operands are registered from the next-state view so they change cleanly on the clock edge.
    gate_a_d = 1'b0;
    gate_b_d = 1'b0;
    if ((state_d == DRIVE) || (state_d == SAMPLE)) begin
      gate_a_d = idx_d[1];
      gate_b_d = idx_d[0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      idx_q      <= 2'd0;
      cnt_q      <= 4'd0;
      gate_a_q   <= 1'b0;
      gate_b_q   <= 1'b0;
      pass_q     <= 1'b0;
      fail_vec_q <= 4'd0;
`ifdef GATE_SEQ_ERRCNT_EN
      err_cnt_q  <= 4'd0;
`endif
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      gate_a_q   <= gate_a_d;
      gate_b_q   <= gate_b_d;
      pass_q     <= pass_d;
      fail_vec_q <= fail_vec_d;
`ifdef GATE_SEQ_ERRCNT_EN
      err_cnt_q  <= err_cnt_d;
`endif
    end
  end

  assign gate_a   = gate_a_q;
  assign gate_b   = gate_b_q;
  assign busy     = (state_q == DRIVE) || (state_q == SAMPLE);
  assign done     = (state_q == DONE);
  assign pass     = pass_q;
  assign fail_vec = fail_vec_q;
`ifdef GATE_SEQ_ERRCNT_EN
  assign err_cnt  = err_cnt_q;
`endif

endmodule

// File: doc/gate_seq_ctrl.md
GATE_SEQ_CTRL -- requirements
Module: gate_seq_ctrl

Interface
REQ-001 Parameter HOLD_CYCLES, default 2, SHALL set the number of cycles each input pattern is held before sampling (legal range 1..15).
REQ-002 Port clk, input, 1, SHALL be the single clock; all state updates on its rising edge.
REQ-003 Port rst, input, 1, SHALL be the reset: synchronous and active-high.
REQ-004 Port start, input, 1, SHALL request one test sequence; honoured only in IDLE.
REQ-005 Port gate_a, output, 1, SHALL drive the shared gate datapath's A operand.
REQ-006 Port gate_b, output, 1, SHALL drive the shared gate datapath's B operand.
REQ-007 Port and_in, input, 1, SHALL carry the AND gate result under test.
REQ-008 Port or_in, input, 1, SHALL carry the OR gate result under test.
REQ-009 Port busy, output, 1, SHALL be high while in DRIVE or SAMPLE.
REQ-010 Port done, output, 1, SHALL pulse high for exactly one cycle at sequence end.
REQ-011 Port pass, output, 1, SHALL report the result of the last completed sequence.
REQ-012 Port fail_vec, output, 4, SHALL flag bit i when pattern i mismatched.

Function
REQ-013 The FSM SHALL have states IDLE, DRIVE, SAMPLE and DONE.
REQ-014 Pattern index idx (2 bits) SHALL map to {gate_a,gate_b} = {idx[1],idx[0]}, applied in the order 00, 01, 10, 11.
REQ-015 IDLE with start=1 SHALL go to DRIVE with idx=0, hold counter=HOLD_CYCLES-1, fail_vec cleared, pass cleared.
REQ-016 DRIVE SHALL decrement the hold counter each cycle and go to SAMPLE on the cycle the counter is 0; DRIVE therefore lasts HOLD_CYCLES cycles.
REQ-017 SAMPLE (1 cycle) SHALL set fail_vec[idx] if and_in != (gate_a & gate_b) or or_in != (gate_a | gate_b).
REQ-018 SAMPLE SHALL go to DONE if idx==3; otherwise it SHALL increment idx, reload the hold counter and return to DRIVE.
REQ-019 DONE SHALL last 1 cycle, assert done, set pass = (final fail_vec == 0) and return to IDLE.
REQ-020 start SHALL be ignored in DRIVE, SAMPLE and DONE; no queuing.
REQ-021 gate_a/gate_b SHALL be 0 in IDLE and DONE, and registered (glitch-free) in DRIVE and SAMPLE.
REQ-022 With start sampled at edge k, done SHALL be high in the cycle after edge k + 4*(HOLD_CYCLES+1).
REQ-023 pass and fail_vec SHALL hold their values in IDLE until the next accepted start.

Reset
REQ-024 rst=1 at any edge SHALL force IDLE, idx=0, hold counter=0, gate_a=0, gate_b=0, busy=0, done=0, pass=0 and fail_vec=0.
REQ-025 rst asserted mid-sequence SHALL abort the sequence without a done pulse; rst has priority over start.

Configuration
REQ-026 Macro GATE_SEQ_ERRCNT_EN defined SHALL add output err_cnt (4 bits), cleared on rst and on an accepted start.
REQ-027 With GATE_SEQ_ERRCNT_EN defined, each SAMPLE SHALL add the number of mismatching signals (0, 1 or 2) to err_cnt, giving a maximum of 8.
REQ-028 Macro GATE_SEQ_ERRCNT_EN undefined SHALL remove the err_cnt port and its logic entirely; all other behaviour is identical.

Verification
REQ-029 Ideal AND/OR model, HOLD_CYCLES=2, start pulse -> gate_a/gate_b step 00,01,10,11 for 3 cycles each; done exactly 12 cycles after the start edge; pass=1, fail_vec=0000.
REQ-030 and_in stuck at 1 -> fail_vec=0111, pass=0; err_cnt=3 when GATE_SEQ_ERRCNT_EN is defined.
REQ-031 or_in inverted -> fail_vec=1111, pass=0; err_cnt=4 when GATE_SEQ_ERRCNT_EN is defined.
REQ-032 start held high continuously for 30 cycles -> first done at +12 cycles, a second sequence begins the cycle after the return to IDLE, and busy never drops mid-sequence.
REQ-033 rst pulsed during pattern 10 -> the next cycle has gate_a=0, gate_b=0, busy=0, fail_vec=0 and no done pulse; a fresh start then completes normally.
REQ-034 HOLD_CYCLES=1 -> each pattern lasts 2 cycles and done arrives 8 cycles after the start edge.
